// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

    localparam int INST_BUFFER_DEPTH = 8;

    // This stage raises no exception of its own; decode sees the INE code here.
    localparam logic [6:0] EXCEPTION_INE = 7'h0d;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pc_exc;
        logic [6:0]  pc_exc_cause;
    } ib_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular FIFO holding fetched {pc, inst, fetch exception} entries
// and presenting the oldest one to the decoder.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = INST_BUFFER_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_pc_exc,
    input  logic [6:0]       in_pc_exc_cause,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [2:0]       out_is_exception,
    output logic [6:0]       out_pc_exception_cause,
    output logic [6:0]       out_instbuffer_exception_cause,

    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    ib_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             deq;
    ib_entry_t        head_entry;

    assign in_ready  = !rst && (count != FULL);
    assign out_valid = (count != '0);

    assign enq = in_valid && in_ready && !flush;
    assign deq = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{pc: in_pc, inst: in_inst,
                           pc_exc: in_pc_exc,
                           pc_exc_cause: in_pc_exc_cause};
        end
    end

    // Flush empties the queue logically; stale array contents stay behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            unique case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head_entry = '0;
        if (out_valid) head_entry = mem[head];
    end

    assign out_pc                         = head_entry.pc;
    assign out_inst                       = head_entry.inst;
    assign out_is_exception               = {head_entry.pc_exc, 2'b00};
    assign out_pc_exception_cause         = head_entry.pc_exc_cause;
    assign out_instbuffer_exception_cause = EXCEPTION_INE;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer against a queue-based model.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pc_exc;
    logic [6:0]  in_pc_exc_cause;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  out_is_exception;
    logic [6:0]  out_pc_exception_cause;
    logic [6:0]  out_instbuffer_exception_cause;
    logic [3:0]  count;

    ib_entry_t q[$];
    int tests = 0;
    int fails = 0;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_inst(in_inst),
        .in_pc_exc(in_pc_exc),
        .in_pc_exc_cause(in_pc_exc_cause),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .out_is_exception(out_is_exception),
        .out_pc_exception_cause(out_pc_exception_cause),
        .out_instbuffer_exception_cause(out_instbuffer_exception_cause),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic exc,
                         input logic [6:0] cause, input logic rdy,
                         input logic fl);
        in_valid        = v;
        in_pc           = pc;
        in_inst         = inst;
        in_pc_exc       = exc;
        in_pc_exc_cause = cause;
        out_ready       = rdy;
        flush           = fl;
    endtask

    // Advance one clock; the model applies the FIFO rules to its queue.
    task automatic tick();
        bit e;
        bit d;
        ib_entry_t n;
        e = in_valid && (q.size() < DEPTH) && !flush;
        d = (q.size() != 0) && out_ready && !flush;
        n = '{pc: in_pc, inst: in_inst, pc_exc: in_pc_exc,
              pc_exc_cause: in_pc_exc_cause};
        if (flush) q.delete();
        else begin
            if (d) void'(q.pop_front());
            if (e) q.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b want 0 0",
                     in_ready, out_valid);
        end
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0 ||
            out_inst !== 32'd0 || out_pc !== 32'd0 ||
            out_instbuffer_exception_cause !== EXCEPTION_INE) begin
            fails++;
            $display("FAIL reset_idle: rdy=%b vld=%b cnt=%0d inst=%h pc=%h ine=%h",
                     in_ready, out_valid, count, out_inst, out_pc,
                     out_instbuffer_exception_cause);
        end
    endtask

    task automatic test_single();
        drive(1, 32'h1c000000, 32'h03800421, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1c000000 ||
            out_inst !== 32'h03800421 || out_is_exception !== 3'b000 ||
            count !== 4'd1) begin
            fails++;
            $display("FAIL single_out: vld=%b pc=%h inst=%h exc=%b cnt=%0d",
                     out_valid, out_pc, out_inst, out_is_exception, count);
        end
        tick();
        tests++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: cnt=%0d vld=%b want 0 0",
                     count, out_valid);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h1c000000 + 32'(4 * i), 32'h100 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        tests++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: cnt=%0d rdy=%b want 8 0", count, in_ready);
        end
        drive(1, 32'hdeadbeef, 32'hdeadbeef, 0, 0, 0, 0);
        tick();
        tests++;
        if (count !== 4'd8) begin
            fails++;
            $display("FAIL fill_ninth: cnt=%0d want 8", count);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h1c000000 + 32'(4 * i) ||
                out_inst !== 32'h100 + 32'(i)) begin
                fails++;
                $display("FAIL drain_order[%0d]: vld=%b pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst);
            end
            tick();
        end
        tests++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: cnt=%0d vld=%b", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h20000000 + 32'(4 * n), $urandom, 0, 0, 0, 0);
            n++;
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, 32'h20000000 + 32'(4 * n), $urandom, 0, 0, 1, 0);
            n++;
            tests++;
            if (count !== 4'd3 || out_pc !== 32'h20000000 + 32'(4 * k) ||
                out_inst !== q[0].inst) begin
                fails++;
                $display("FAIL b2b[%0d]: cnt=%0d pc=%h want 3 %h", k, count,
                         out_pc, 32'h20000000 + 32'(4 * k));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        while (q.size() != 0) tick();
    endtask

    task automatic test_exception();
        drive(1, 32'h30000000, 32'h1, 0, 7'h00, 0, 0);
        tick();
        drive(1, 32'h30000004, 32'h2, 1, 7'h08, 0, 0);
        tick();
        drive(1, 32'h30000008, 32'h3, 0, 7'h00, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_pc !== 32'h30000000 + 32'(4 * i) ||
                out_is_exception !== ((i == 1) ? 3'b100 : 3'b000) ||
                out_pc_exception_cause !== ((i == 1) ? 7'h08 : 7'h00)) begin
                fails++;
                $display("FAIL exc_order[%0d]: pc=%h exc=%b cause=%h",
                         i, out_pc, out_is_exception, out_pc_exception_cause);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h40000000 + 32'(4 * i), $urandom, 0, 0, 0, 0);
            tick();
        end
        tests++;
        if (count !== 4'd5) begin
            fails++;
            $display("FAIL flush_pre: cnt=%0d want 5", count);
        end
        drive(1, 32'h00000bad, 32'h00000bad, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
            fails++;
            $display("FAIL flush_empty: cnt=%0d vld=%b pc=%h",
                     count, out_valid, out_pc);
        end
        drive(1, 32'h50000000, 32'h55, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h50000000 || count !== 4'd1) begin
            fails++;
            $display("FAIL flush_after: vld=%b pc=%h cnt=%0d",
                     out_valid, out_pc, count);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ep;
        logic [31:0] ei;
        logic [2:0]  ex;
        logic [6:0]  ec;
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 7) == 0), 7'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0));
            ep = (q.size() != 0) ? q[0].pc : 32'd0;
            ei = (q.size() != 0) ? q[0].inst : 32'd0;
            ex = (q.size() != 0) ? {q[0].pc_exc, 2'b00} : 3'b000;
            ec = (q.size() != 0) ? q[0].pc_exc_cause : 7'd0;
            tests++;
            if (count !== 4'(q.size()) ||
                out_valid !== (q.size() != 0) ||
                in_ready !== (q.size() < DEPTH) ||
                out_pc !== ep || out_inst !== ei ||
                out_is_exception !== ex || out_pc_exception_cause !== ec) begin
                fails++;
                $display("FAIL random[%0d]: cnt=%0d/%0d pc=%h/%h inst=%h/%h exc=%b/%b",
                         k, count, q.size(), out_pc, ep, out_inst, ei,
                         out_is_exception, ex);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_exception();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Single-clock instruction buffer between fetch and decode. It stores fetched {pc, inst, pc-stage exception} entries in a DEPTH-entry circular FIFO and presents the oldest entry to the decoder. The decoder consumes the pc, inst, is_exception and per-stage exception-cause fields produced here. The buffer discards all contents on a pipeline flush.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ 2
- PTR_W, $clog2(DEPTH), localparam; head/tail pointer width
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all entries (branch mispredict / exception)
- in_valid  input  1  fetch presents an entry
- in_ready  output  1  buffer can accept an entry this cycle
- in_pc  input  32  fetch pc
- in_inst  input  32  fetched instruction word
- in_pc_exc  input  1  fetch-stage exception flag (e.g. ADEF)
- in_pc_exc_cause  input  7  fetch-stage exception code
- out_valid  output  1  head entry is valid
- out_ready  input  1  decoder accepts the head entry
- out_pc  output  32  head pc
- out_inst  output  32  head instruction
- out_is_exception  output  3  {pc-stage, instbuffer-stage, decoder-stage}; bits [1:0] always 0
- out_pc_exception_cause  output  7  head fetch-stage cause
- out_instbuffer_exception_cause  output  7  constant `EXCEPTION_INE (this stage raises no exception)
- count  output  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- State: storage array[DEPTH], head (read pointer), tail (write pointer), count. All are registers. No FSM beyond the occupancy counter.
- Enqueue fires when in_valid && in_ready && !flush. It writes array[tail] and sets tail <= tail+1.
- Dequeue fires when out_valid && out_ready && !flush. It sets head <= head+1.
- count update: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither fire.
- Pointers wrap modulo DEPTH through natural PTR_W-bit overflow.
- in_ready = !rst && (count != DEPTH). At full, a simultaneous dequeue does not reopen in_ready in the same cycle (no full-bypass).
- out_valid = (count != 0). There is no empty-bypass: an entry enqueued in cycle N is visible no earlier than cycle N+1.
- Outputs are read combinationally from array[head]. When out_valid=0, out_pc, out_inst, out_is_exception and out_pc_exception_cause are all 0.
- out_is_exception[2] = stored in_pc_exc. out_is_exception[1:0] = 2'b00.
- Flush: in the next cycle head=tail=count=0. Any enqueue or dequeue presented in the flush cycle is dropped. Array contents are not cleared.
- Flush has priority over enqueue and dequeue. Reset has priority over flush.
- Entries with in_pc_exc=1 are buffered and ordered like normal entries; the buffer does not drop or reorder them.

## Timing
- Reset (rst=1 at an edge): head=0, tail=0, count=0.
  - While rst=1: in_ready=0 and out_valid=0.
  - First cycle after reset: in_ready=1, out_valid=0, all data outputs 0, out_instbuffer_exception_cause=`EXCEPTION_INE.
- Enqueue-to-out_valid latency is 1 cycle. Sustained throughput is 1 entry/cycle in and 1 entry/cycle out whenever 0 < count < DEPTH.
- out_* fields stay stable while out_valid=1 && out_ready=0.
- Reset or flush mid-stream takes effect at the same edge. Entries in flight are lost; fetch re-supplies them.

## Structure
- `EXCEPTION_INE and the other EXCEPTION_* codes come from the existing csr_defines.vh/defines.vh.
- Add `INST_BUFFER_DEPTH (8) to defines.vh. It is the default for DEPTH at the instantiation site.
- Keep the block flat: one module, with the storage array as a reg array. No sub-module; the FIFO logic is too small to split.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, count=0, out_inst=0, out_instbuffer_exception_cause=`EXCEPTION_INE.
- Enqueue pc=0x1c000000 / inst=0x03800421 in cycle 0 → out_valid=1 in cycle 1 with the same pc/inst and out_is_exception=3'b000. out_ready=1 → count returns to 0 in cycle 2.
- Hold out_ready=0 and push 8 entries → count=8 and in_ready=0. A 9th in_valid is not accepted. Then assert out_ready for 8 cycles → entries emerge in order pc=0x1c000000..0x1c00001c, and the pointers wrap cleanly on refill.
- Keep in_valid=out_ready=1 for 20 cycles with count held at 3 → count stays at 3 and output order is exact FIFO order.
- Enqueue in_pc_exc=1 with cause 0x08 → out_is_exception=3'b100 and out_pc_exception_cause=0x08 at the head, in its program-order position.
- With count=5, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, and the flushed-cycle entry is not present. The following enqueue appears 1 cycle later.
